controle_barramento: RTL
========================

CONTROLE_BARRAMENTO -- requirements
Module: controle_barramento

Interface
REQ-001 Parameter ADDR_W, default 8, block-address width.
REQ-002 Parameter TIMEOUT_CICLOS, default 16, memory-ack watchdog limit (used only under BUS_TIMEOUT_EN).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  2  per-requester bus request (bit 0 = P0, bit 1 = P1), held until done.
REQ-006 msg0, msg1  in  2 each  coherence message of P0/P1: 00 invalidar, 01 readMiss, 10 writeMiss, 11 semMensagem.
REQ-007 end0, end1  in  ADDR_W each  block address of P0/P1.
REQ-008 grant  out  2  one-hot bus ownership.
REQ-009 bus_msg  out  2  broadcast message; 11 when not broadcasting.
REQ-010 bus_end  out  ADDR_W  broadcast address.
REQ-011 bus_valido  out  1  snoopers sample bus_msg/bus_end this cycle.
REQ-012 snoop_wb, snoop_abort  in  1 each  OR-ed snooper writeBack / abortAccessMemory replies.
REQ-013 mem_req  out  1; mem_we  out  1 (1 = write-back); mem_ack  in  1 memory handshake.
REQ-014 done  out  2  one-hot, one-cycle completion pulse to the winner.
REQ-015 erro  out  1  one-cycle timeout pulse (0 when feature compiled out).

Function
REQ-016 FSM states SHALL be OCIOSO, DIFUNDE, SNOOP, WRITEBACK, MEMORIA, CONCLUI.
REQ-017 OCIOSO: requester eligible if req=1 and msg!=11; among eligible, round-robin (last winner lowest priority); winner's msg/end latched; next state DIFUNDE.
REQ-018 grant SHALL be asserted for the winner from DIFUNDE through CONCLUI inclusive, 0 otherwise.
REQ-019 DIFUNDE: bus_valido=1 exactly one cycle with latched bus_msg/bus_end; next SNOOP.
REQ-020 SNOOP: sample snoop_wb/snoop_abort; invalidar -> CONCLUI; else snoop_wb=1 -> WRITEBACK; else -> MEMORIA.
REQ-021 WRITEBACK: mem_req=1, mem_we=1 until mem_ack; on ack, abort sampled 1 -> CONCLUI, else MEMORIA.
REQ-022 MEMORIA: mem_req=1, mem_we=0 until mem_ack; on ack -> CONCLUI.
REQ-023 CONCLUI: done[winner]=1 one cycle, round-robin pointer updated, next OCIOSO.
REQ-024 Minimum latency: invalidar sampled in OCIOSO at cycle 0 -> done at cycle 3.
REQ-025 req dropped mid-transaction SHALL NOT abort it; msg/end changes after latch ignored.
REQ-026 mem_ack outside WRITEBACK/MEMORIA SHALL be ignored; mem_ack in same cycle as mem_req rise is valid.
REQ-027 Both requesters eligible simultaneously after reset: P0 wins.

Reset
REQ-028 reset SHALL force OCIOSO, grant=0, bus_msg=11, bus_end=0, bus_valido=0, mem_req=0, mem_we=0, done=0, erro=0, pointer favouring P0, watchdog=0, including mid-transaction (no done issued).

Configuration
REQ-029 Macro BUS_TIMEOUT_EN: defined -> watchdog counts cycles in WRITEBACK/MEMORIA, reset on state entry; TIMEOUT_CICLOS cycles without mem_ack -> erro pulse, mem_req dropped, -> CONCLUI (done still pulsed).
REQ-030 Undefined -> no watchdog, wait indefinitely, erro tied 0.

Structure
REQ-031 Shared package pacote_coerencia SHALL hold message codes, MSI state codes, processor-op codes and FSM state encoding.
REQ-032 Sub-module arbitro_rr (2-way round-robin, pointer register) SHALL be instantiated once.

Verification
REQ-033 P0 invalidar, addr 0x12 -> bus_valido cycle 1 with bus_msg=00/bus_end=0x12, done=01 cycle 3, no mem_req.
REQ-034 P1 readMiss, snoop_wb=1, snoop_abort=1, ack after 2 cycles -> one write-back (mem_we=1), no read, done=10.
REQ-035 P0 writeMiss, no snoop reply, ack after 4 cycles -> mem_req mem_we=0 4 cycles, done=01.
REQ-036 req=11 both readMiss held -> grants P0, P1, P0 alternating; done never both bits.
REQ-037 reset asserted in MEMORIA -> next cycle all outputs at reset values, no done.
REQ-038 BUS_TIMEOUT_EN, mem_ack never -> erro at 16th waiting cycle, then done; without macro mem_req held 100+ cycles.

Source files
------------

// File: rtl/pacote_coerencia.sv
// Shared coherence encodings: bus messages, MSI line states, processor ops,
// bus-controller FSM states and the requester eligibility rule.
package pacote_coerencia;

   typedef enum logic [1:0] {
      MSG_INVALIDAR  = 2'b00,
      MSG_READ_MISS  = 2'b01,
      MSG_WRITE_MISS = 2'b10,
      MSG_NENHUMA    = 2'b11
   } msg_t;

   typedef enum logic [1:0] {
      MSI_INVALIDO      = 2'b00,
      MSI_COMPARTILHADO = 2'b01,
      MSI_MODIFICADO    = 2'b10
   } msi_t;

   typedef enum logic [1:0] {
      OP_NENHUMA = 2'b00,
      OP_LEITURA = 2'b01,
      OP_ESCRITA = 2'b10
   } op_t;

   typedef enum logic [2:0] {
      OCIOSO,
      DIFUNDE,
      SNOOP,
      WRITEBACK,
      MEMORIA,
      CONCLUI
   } estado_t;

   function automatic logic elegivel(input logic pedido, input logic [1:0] msg);
      return pedido && (msg != MSG_NENHUMA);
   endfunction

endpackage

// File: rtl/controle_barramento_if.sv
// Bus bundle between the coherence bus controller (master) and the
// requesters / snoopers / memory around it (slave).
interface controle_barramento_if #(
   parameter int ADDR_W = 8
);
   logic [1:0]        req;
   logic [1:0]        msg0;
   logic [1:0]        msg1;
   logic [ADDR_W-1:0] end0;
   logic [ADDR_W-1:0] end1;
   logic [1:0]        grant;
   logic [1:0]        bus_msg;
   logic [ADDR_W-1:0] bus_end;
   logic              bus_valido;
   logic              snoop_wb;
   logic              snoop_abort;
   logic              mem_req;
   logic              mem_we;
   logic              mem_ack;
   logic [1:0]        done;
   logic              erro;

   modport master (
      input  req, msg0, msg1, end0, end1, snoop_wb, snoop_abort, mem_ack,
      output grant, bus_msg, bus_end, bus_valido, mem_req, mem_we, done, erro
   );

   modport slave (
      output req, msg0, msg1, end0, end1, snoop_wb, snoop_abort, mem_ack,
      input  grant, bus_msg, bus_end, bus_valido, mem_req, mem_we, done, erro
   );
endinterface

// File: rtl/arbitro_rr.sv
// Two-way round-robin arbiter; the pointer remembers the last winner, which
// gets lowest priority when both requesters are eligible.
module arbitro_rr (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] elig,
   input  logic       atualiza,
   input  logic       vencedor_fim,
   output logic       algum,
   output logic       vencedor
);
   logic ultimo;

   // Reset value 1 makes P0 the favoured requester.
   always_ff @(posedge clock) begin
      if (reset)
         ultimo <= 1'b1;
      else if (atualiza)
         ultimo <= vencedor_fim;
   end

   always_comb begin
      algum = |elig;
      if (elig == 2'b11)
         vencedor = ~ultimo;
      else
         vencedor = elig[1];
   end
endmodule

// File: rtl/controle_barramento.sv
// Snooping-bus controller: arbitrates P0/P1, broadcasts, handles write-back
// and memory access. Optional memory-ack watchdog under `BUS_TIMEOUT_EN.
module controle_barramento
   import pacote_coerencia::*;
#(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CICLOS = 16
) (
   input logic                  clock,
   input logic                  reset,
   controle_barramento_if.master bus
);
   estado_t           estado, prox;
   logic              dono;
   logic [1:0]        msg_q;
   logic [ADDR_W-1:0] end_q;
   logic              abort_q;
   logic [1:0]        elig;
   logic              algum;
   logic              vencedor;
   logic              esperando;
   logic              timeout;

   assign elig      = {elegivel(bus.req[1], bus.msg1), elegivel(bus.req[0], bus.msg0)};
   assign esperando = (estado == WRITEBACK) || (estado == MEMORIA);

   arbitro_rr u_arbitro (
      .clock        (clock),
      .reset        (reset),
      .elig         (elig),
      .atualiza     (estado == CONCLUI),
      .vencedor_fim (dono),
      .algum        (algum),
      .vencedor     (vencedor)
   );

`ifdef BUS_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CICLOS + 1);
   logic [WD_W-1:0] wd;

   // Counter restarts whenever the FSM changes state, so WRITEBACK->MEMORIA
   // gets a fresh budget.
   always_ff @(posedge clock) begin
      if (reset)
         wd <= '0;
      else if (prox != estado)
         wd <= '0;
      else if (esperando)
         wd <= wd + 1'b1;
   end

   assign timeout = esperando && !bus.mem_ack && (wd == WD_W'(TIMEOUT_CICLOS - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado  <= OCIOSO;
         dono    <= 1'b0;
         msg_q   <= MSG_NENHUMA;
         end_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         estado <= prox;
         if (estado == OCIOSO && algum) begin
            dono  <= vencedor;
            msg_q <= vencedor ? bus.msg1 : bus.msg0;
            end_q <= vencedor ? bus.end1 : bus.end0;
         end
         if (estado == SNOOP)
            abort_q <= bus.snoop_abort;
      end
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:    if (algum) prox = DIFUNDE;
         DIFUNDE:   prox = SNOOP;
         SNOOP: begin
            if (msg_q == MSG_INVALIDAR)
               prox = CONCLUI;
            else if (bus.snoop_wb)
               prox = WRITEBACK;
            else
               prox = MEMORIA;
         end
         WRITEBACK: begin
            if (bus.mem_ack)
               prox = abort_q ? CONCLUI : MEMORIA;
            else if (timeout)
               prox = CONCLUI;
         end
         MEMORIA:   if (bus.mem_ack || timeout) prox = CONCLUI;
         CONCLUI:   prox = OCIOSO;
         default:   prox = OCIOSO;
      endcase
   end

   always_comb begin
      bus.grant      = '0;
      bus.bus_msg    = MSG_NENHUMA;
      bus.bus_end    = '0;
      bus.bus_valido = 1'b0;
      bus.mem_req    = esperando;
      bus.mem_we     = (estado == WRITEBACK);
      bus.done       = '0;
      bus.erro       = timeout;
      if (estado != OCIOSO)
         bus.grant = dono ? 2'b10 : 2'b01;
      if (estado == DIFUNDE) begin
         bus.bus_valido = 1'b1;
         bus.bus_msg    = msg_q;
         bus.bus_end    = end_q;
      end
      if (estado == CONCLUI)
         bus.done = dono ? 2'b10 : 2'b01;
   end
endmodule
